// File: rtl/display_timing_gen.sv
// VGA-style raster timing: pixel-rate divider, h/v counters, registered sync and bright decodes.
// Optional frame_tick game-update strobe, built only when DISPLAY_FRAME_TICK_EN is defined.
module display_timing_gen #(
    parameter int         CLK_DIV     = 4,
    parameter int         H_TOTAL     = 800,
    parameter int         H_SYNC      = 96,
    parameter int         H_ACT_START = 144,
    parameter int         H_ACT_END   = 783,
    parameter int         V_TOTAL     = 525,
    parameter int         V_SYNC      = 2,
    parameter int         V_ACT_START = 35,
    parameter int         V_ACT_END   = 514,
    parameter logic [7:0] FRAME_DIV   = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYN    = 10'(H_SYNC);
    localparam logic [9:0]       V_SYN    = 10'(V_SYNC);
    localparam logic [9:0]       HA_S     = 10'(H_ACT_START);
    localparam logic [9:0]       HA_E     = 10'(H_ACT_END);
    localparam logic [9:0]       VA_S     = 10'(V_ACT_START);
    localparam logic [9:0]       VA_E     = 10'(V_ACT_END);

    logic             run_q, run_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             h_wrap;

    // The first edge after release only arms the divider, so the first pix_en
    // lands exactly CLK_DIV clocks after reset is released.
    always_comb begin
        run_d    = 1'b1;
        div_d    = '0;
        h_d      = h_q;
        v_d      = v_q;
        h_wrap   = 1'b0;
        if (run_q && (div_q != DIV_LAST)) begin
            div_d = div_q + 1'b1;
        end
        pix_en_d = (div_d == DIV_LAST);
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                h_wrap = 1'b1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        if (h_wrap) begin
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end
        // Decodes look at next-state counts so they switch on the same edge as the counters.
        hsync_d  = (h_d >= H_SYN);
        vsync_d  = (v_d >= V_SYN);
        bright_d = (h_d >= HA_S) && (h_d <= HA_E) && (v_d >= VA_S) && (v_d <= VA_E);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
        end
    end

    assign hCount = h_q;
    assign vCount = v_q;
    assign hSync  = hsync_q;
    assign vSync  = vsync_q;
    assign bright = bright_q;
    assign pix_en = pix_en_q;

`ifdef DISPLAY_FRAME_TICK_EN
    localparam logic [7:0] FRAME_DIV_EFF = (FRAME_DIV == 8'd0) ? 8'd1 : FRAME_DIV;

    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_tick_q, frame_tick_d;
    logic       last_vis;

    // A frame is counted when its last visible pixel is consumed.
    always_comb begin
        last_vis     = pix_en_q && (h_q == HA_E) && (v_q == VA_E);
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;
        if (last_vis) begin
            if (frame_cnt_q == FRAME_DIV_EFF - 8'd1) begin
                frame_cnt_d  = '0;
                frame_tick_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen on a shrunken raster (20x10 pixels, 4 clk/pixel).
// Two instances share clock/reset: FRAME_DIV=3 and FRAME_DIV=0.
module tb_display_timing_gen;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 20;
    localparam int H_SYNC      = 3;
    localparam int H_ACT_START = 5;
    localparam int H_ACT_END   = 16;
    localparam int V_TOTAL     = 10;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 3;
    localparam int V_ACT_END   = 7;
    localparam int LINE_CLK    = CLK_DIV * H_TOTAL;
    localparam int FRAME_CLK   = LINE_CLK * V_TOTAL;
    localparam int SCAN_CYC    = 5200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_cnt, v_cnt, h_cnt_b, v_cnt_b;
    logic       h_sync, v_sync, bright, pix_en, frame_tick;
    logic       h_sync_b, v_sync_b, bright_b, pix_en_b, frame_tick_b;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    display_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
        .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END), .FRAME_DIV(8'd3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .hCount(h_cnt), .vCount(v_cnt),
        .hSync(h_sync), .vSync(v_sync), .bright(bright), .pix_en(pix_en),
        .frame_tick(frame_tick)
    );

    display_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
        .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END), .FRAME_DIV(8'd0)
    ) u_dut_div0 (
        .clk(clk), .rst_n(rst_n), .hCount(h_cnt_b), .vCount(v_cnt_b),
        .hSync(h_sync_b), .vSync(v_sync_b), .bright(bright_b), .pix_en(pix_en_b),
        .frame_tick(frame_tick_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_and_check(input string tag);
        logic [4:0] pe_seq;
        int h4;
        int h5;
        pe_seq = '0;
        h4 = -1;
        h5 = -1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        chk({tag, "_outs_at_release"},
            int'({h_cnt, v_cnt, h_sync, v_sync, bright, pix_en, frame_tick}), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            pe_seq[k] = pix_en;
            if (k == 3) h4 = int'(h_cnt);
            if (k == 4) h5 = int'(h_cnt);
        end
        chk({tag, "_pix_en_first_clk4"}, int'(pe_seq), 8);
        chk({tag, "_hcount_after_clk4"}, h4, 0);
        chk({tag, "_hcount_after_clk5"}, h5, 1);
    endtask

    initial begin
        int prev_h, prev_v, prev_pe, prev_hs, prev_vs, prev_br, prev_ft, prev_ftb;
        int range_bad, hold_bad, skew_bad, bright_bad, outside_bad;
        int pe_cnt, br_cnt, line_wraps, vinc_bad, first_wrap_cyc, first_wrap_v;
        int last_wrap, line_bad, frame_wraps, last_frame, frame_bad;
        int hs_fall, hs_runs, hs_bad, vs_fall, vs_runs, vs_bad;
        int rises, falls, rise_h, rise_v, fall_h, fall_v;
        int ft_cnt, ft_first, ft_last, ft_gap_bad, ft_wide, ft_pos_bad;
        int ftb_cnt, ftb_first, ftb_last, ftb_gap_bad, ftb_wide;
        int found;
        logic exp_br;

        range_bad = 0; hold_bad = 0; skew_bad = 0; bright_bad = 0; outside_bad = 0;
        pe_cnt = 0; br_cnt = 0; line_wraps = 0; vinc_bad = 0;
        first_wrap_cyc = -1; first_wrap_v = -1;
        last_wrap = 0; line_bad = 0; frame_wraps = 0; last_frame = 0; frame_bad = 0;
        hs_fall = -1; hs_runs = 0; hs_bad = 0; vs_fall = -1; vs_runs = 0; vs_bad = 0;
        rises = 0; falls = 0; rise_h = -1; rise_v = -1; fall_h = -1; fall_v = -1;
        ft_cnt = 0; ft_first = -1; ft_last = 0; ft_gap_bad = 0; ft_wide = 0; ft_pos_bad = 0;
        ftb_cnt = 0; ftb_first = -1; ftb_last = 0; ftb_gap_bad = 0; ftb_wide = 0;
        found = 0;

        // Power-on reset held for 10 clocks.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_hcount", int'(h_cnt), 0);
        chk("rst_vcount", int'(v_cnt), 0);
        chk("rst_hsync", int'(h_sync), 0);
        chk("rst_vsync", int'(v_sync), 0);
        chk("rst_bright", int'(bright), 0);
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_frame_tick", int'(frame_tick), 0);
        chk("rst_div0_outs",
            int'({h_cnt_b, v_cnt_b, h_sync_b, v_sync_b, bright_b, pix_en_b, frame_tick_b}), 0);

        release_and_check("por");

        // Free-running scan over several frames.
        for (int n = 0; n < SCAN_CYC; n++) begin
            prev_h = int'(h_cnt); prev_v = int'(v_cnt); prev_pe = int'(pix_en);
            prev_hs = int'(h_sync); prev_vs = int'(v_sync); prev_br = int'(bright);
            prev_ft = int'(frame_tick); prev_ftb = int'(frame_tick_b);
            tick();
            if (int'(h_cnt) >= H_TOTAL || int'(v_cnt) >= V_TOTAL) range_bad++;
            if (prev_pe == 0 && (int'(h_cnt) != prev_h || int'(v_cnt) != prev_v)) hold_bad++;
            if (h_sync !== (int'(h_cnt) >= H_SYNC)) skew_bad++;
            if (v_sync !== (int'(v_cnt) >= V_SYNC)) skew_bad++;
            exp_br = (int'(h_cnt) >= H_ACT_START) && (int'(h_cnt) <= H_ACT_END) &&
                     (int'(v_cnt) >= V_ACT_START) && (int'(v_cnt) <= V_ACT_END);
            if (bright !== exp_br) bright_bad++;
            if (bright && (int'(v_cnt) < V_ACT_START || int'(v_cnt) > V_ACT_END)) outside_bad++;
            if (pix_en) pe_cnt++;
            if (bright) br_cnt++;
            if (prev_h == H_TOTAL - 1 && h_cnt == 10'd0) begin
                line_wraps++;
                if (int'(v_cnt) != (prev_v + 1) % V_TOTAL) vinc_bad++;
                if (line_wraps == 1) begin
                    first_wrap_cyc = cyc;
                    first_wrap_v = int'(v_cnt);
                end else if (cyc - last_wrap != LINE_CLK) begin
                    line_bad++;
                end
                last_wrap = cyc;
                if (prev_v == V_TOTAL - 1 && v_cnt == 10'd0) begin
                    frame_wraps++;
                    if (frame_wraps > 1 && cyc - last_frame != FRAME_CLK) frame_bad++;
                    last_frame = cyc;
                end
            end
            if (prev_hs == 1 && !h_sync) hs_fall = cyc;
            if (prev_hs == 0 && h_sync && hs_fall >= 0) begin
                hs_runs++;
                if (cyc - hs_fall != H_SYNC * CLK_DIV) hs_bad++;
            end
            if (prev_vs == 1 && !v_sync) vs_fall = cyc;
            if (prev_vs == 0 && v_sync && vs_fall >= 0) begin
                vs_runs++;
                if (cyc - vs_fall != V_SYNC * LINE_CLK) vs_bad++;
            end
            if (prev_br == 0 && bright) begin
                rises++;
                if (rises == 1) begin rise_h = int'(h_cnt); rise_v = int'(v_cnt); end
            end
            if (prev_br == 1 && !bright) begin
                falls++;
                if (falls == 1) begin fall_h = int'(h_cnt); fall_v = int'(v_cnt); end
            end
            if (frame_tick) begin
                if (prev_ft == 1) ft_wide++;
                else begin
                    ft_cnt++;
                    if (ft_cnt == 1) ft_first = cyc;
                    else if (cyc - ft_last != 3 * FRAME_CLK) ft_gap_bad++;
                    ft_last = cyc;
                    if (int'(h_cnt) != H_ACT_END + 1 || int'(v_cnt) != V_ACT_END) ft_pos_bad++;
                end
            end
            if (frame_tick_b) begin
                if (prev_ftb == 1) ftb_wide++;
                else begin
                    ftb_cnt++;
                    if (ftb_cnt == 1) ftb_first = cyc;
                    else if (cyc - ftb_last != FRAME_CLK) ftb_gap_bad++;
                    ftb_last = cyc;
                end
            end
        end

        chk("count_range", range_bad, 0);
        chk("count_hold_without_pix_en", hold_bad, 0);
        chk("sync_skew", skew_bad, 0);
        chk("bright_window", bright_bad, 0);
        chk("bright_outside_lines", outside_bad, 0);
        chk("pix_en_pulses", pe_cnt, 1300);
        chk("bright_cycles", br_cnt, 1536);
        chk("first_line_wrap_cyc", first_wrap_cyc, 81);
        chk("first_line_wrap_vcount", first_wrap_v, 1);
        chk("line_wraps", line_wraps, 65);
        chk("vcount_increment", vinc_bad, 0);
        chk("line_period", line_bad, 0);
        chk("frame_wraps", frame_wraps, 6);
        chk("frame_period", frame_bad, 0);
        chk("hsync_runs", hs_runs, 64);
        chk("hsync_width", hs_bad, 0);
        chk("vsync_runs", vs_runs, 6);
        chk("vsync_width", vs_bad, 0);
        chk("bright_rise_h", rise_h, H_ACT_START);
        chk("bright_rise_v", rise_v, V_ACT_START);
        chk("bright_fall_h", fall_h, H_ACT_END + 1);
        chk("bright_fall_v", fall_v, V_ACT_START);
`ifdef DISPLAY_FRAME_TICK_EN
        chk("ftick_div3_count", ft_cnt, 2);
        chk("ftick_div3_first", ft_first, 2229);
        chk("ftick_div3_spacing", ft_gap_bad, 0);
        chk("ftick_div3_width", ft_wide, 0);
        chk("ftick_div3_position", ft_pos_bad, 0);
        chk("ftick_div0_count", ftb_cnt, 6);
        chk("ftick_div0_first", ftb_first, 629);
        chk("ftick_div0_spacing", ftb_gap_bad, 0);
        chk("ftick_div0_width", ftb_wide, 0);
`else
        chk("ftick_off_count", ft_cnt + ft_wide, 0);
        chk("ftick_off_div0_count", ftb_cnt + ftb_wide, 0);
`endif

        // Asynchronous reset dropped mid-frame, between clock edges.
        for (int n = 0; n < 2 * FRAME_CLK && found == 0; n++) begin
            tick();
            if (h_cnt == 10'd10 && v_cnt == 10'd5) found = 1;
        end
        chk("async_point_found", found, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs",
            int'({h_cnt, v_cnt, h_sync, v_sync, bright, pix_en, frame_tick}), 0);
        chk("async_rst_div0_outs",
            int'({h_cnt_b, v_cnt_b, h_sync_b, v_sync_b, bright_b, pix_en_b, frame_tick_b}), 0);
        repeat (3) @(posedge clk);
        release_and_check("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
